// File: rtl/sub_bytes_iter_pkg.sv
// ---------------------------------------------------------------------------
// aes_sb_pkg
// Shared definitions for the iterative SubBytes engine:
//   - state_e         : engine FSM states (IDLE, BUSY, DONE)
//   - ncyc()          : cycles per block for a given lane count
//   - lanes_legal()   : accepted lane counts (1, 2, 4, 8, 16)
//   - GF(2^8) helpers : used by the forward / inverse S-box modules
// ---------------------------------------------------------------------------
package aes_sb_pkg;

   localparam int BLOCK_W     = 128;
   localparam int BLOCK_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int ncyc(input int lanes);
      return BLOCK_BYTES / lanes;
   endfunction

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
             (lanes == 8) || (lanes == 16);
   endfunction

   // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Forward affine map: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
   function automatic logic [7:0] fwd_affine(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
             {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// ---------------------------------------------------------------------------
// sub_bytes_iter_if
// Valid/ready bus of the iterative SubBytes engine. Signal names are seen
// from the engine side (i_ = into the engine, o_ = out of the engine).
//   i_Valid / o_Ready : input block handshake
//   i_Dec             : 1 = inverse S-box, 0 = forward, sampled on accept
//   i_Din             : input state, [127:120] is byte 0
//   o_Valid / i_Ready : result handshake, o_Valid held until taken
//   o_Dout            : substituted state, same byte order as i_Din
//   o_Busy            : engine is substituting
// Modports: slave = engine, master = surrounding round logic.
// ---------------------------------------------------------------------------
interface sub_bytes_iter_if;
   import aes_sb_pkg::*;

   logic               i_Valid;
   logic               o_Ready;
   logic               i_Dec;
   logic [BLOCK_W-1:0] i_Din;
   logic               o_Valid;
   logic               i_Ready;
   logic [BLOCK_W-1:0] o_Dout;
   logic               o_Busy;

   modport slave (
      input  i_Valid, i_Dec, i_Din, i_Ready,
      output o_Ready, o_Valid, o_Dout, o_Busy
   );

   modport master (
      output i_Valid, i_Dec, i_Din, i_Ready,
      input  o_Ready, o_Valid, o_Dout, o_Busy
   );

endinterface

// File: rtl/sub_bytes_iter_lane.sv
// ---------------------------------------------------------------------------
// aes_sbox / aes_inv_sbox / sub_bytes_lane
// aes_sbox     : forward AES S-box (i_Byte -> o_Byte)
// aes_inv_sbox : inverse AES S-box (i_Byte -> o_Byte)
// sub_bytes_lane : one byte lane of the SubBytes engine; both S-boxes are
//   evaluated and i_Dec selects the inverse (1) or forward (0) result.
//   Ports: i_Byte [7:0] in, i_Dec in, o_Byte [7:0] out.
// ---------------------------------------------------------------------------
module aes_sbox
   import aes_sb_pkg::*;
(
   input  logic [7:0] i_Byte,
   output logic [7:0] o_Byte
);
   assign o_Byte = fwd_affine(gf_inv(i_Byte));
endmodule

module aes_inv_sbox
   import aes_sb_pkg::*;
(
   input  logic [7:0] i_Byte,
   output logic [7:0] o_Byte
);
   assign o_Byte = gf_inv(inv_affine(i_Byte));
endmodule

module sub_bytes_lane (
   input  logic [7:0] i_Byte,
   input  logic       i_Dec,
   output logic [7:0] o_Byte
);
   logic [7:0] fwd_byte;
   logic [7:0] inv_byte;

   aes_sbox u_fwd (
      .i_Byte (i_Byte),
      .o_Byte (fwd_byte)
   );

   aes_inv_sbox u_inv (
      .i_Byte (i_Byte),
      .o_Byte (inv_byte)
   );

   assign o_Byte = i_Dec ? inv_byte : fwd_byte;
endmodule

// File: rtl/sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// sub_bytes_iter
// Multi-cycle SubBytes engine: substitutes the 16 bytes of a 128-bit state
// through LANES byte lanes, taking 16/LANES cycles per block.
//   LANES : lanes instantiated (1, 2, 4, 8 or 16)
//   i_Clk : clock, rising edge
//   i_Rst : asynchronous, active-high reset
//   bus   : sub_bytes_iter_if.slave (input/result valid-ready handshake)
// The working register rotates right by LANES bytes each step, with the
// freshly substituted bytes entering at the top, so after 16/LANES steps
// every byte is substituted and back in its original position.
// ---------------------------------------------------------------------------
module sub_bytes_iter
   import aes_sb_pkg::*;
#(
   parameter int LANES = 4
)
(
   input  logic             i_Clk,
   input  logic             i_Rst,
   sub_bytes_iter_if.slave  bus
);

   localparam int NCYC   = ncyc(LANES);
   localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam int LANE_W = LANES * 8;

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   state_e             state_q;
   state_e             state_d;
   logic [BLOCK_W-1:0] w_q;
   logic [BLOCK_W-1:0] w_rot;
   logic               m_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [LANE_W-1:0]  subst;
   logic               load;
   logic               step;

   // Substitute the lowest LANES bytes of the working register.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sub_bytes_lane u_lane (
         .i_Byte (w_q[i*8 +: 8]),
         .i_Dec  (m_q),
         .o_Byte (subst[i*8 +: 8])
      );
   end

   // With 16 lanes the whole state is replaced; there is nothing to rotate.
   if (LANES == BLOCK_BYTES) begin : g_full
      assign w_rot = subst;
   end else begin : g_rot
      assign w_rot = {subst, w_q[BLOCK_W-1:LANE_W]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would infer a latch.
      state_d     = state_q;
      bus.o_Ready = 1'b0;
      bus.o_Valid = 1'b0;
      bus.o_Busy  = 1'b0;
      load        = 1'b0;
      step        = 1'b0;
      case (state_q)
         IDLE: begin
            bus.o_Ready = 1'b1;
            if (bus.i_Valid) begin
               load    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            bus.o_Busy = 1'b1;
            step       = 1'b1;
            if (cnt_q == CNT_W'(NCYC - 1)) state_d = DONE;
         end
         DONE: begin
            bus.o_Valid = 1'b1;
            // Ready depends only on i_Ready here; i_Valid only picks the
            // next state (back-to-back reload vs. return to idle).
            if (bus.i_Ready) begin
               bus.o_Ready = 1'b1;
               if (bus.i_Valid) begin
                  load    = 1'b1;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the working register is a plain 128-bit register, not a memory,
   // so it is reset to give a defined o_Dout of zero out of reset.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         w_q   <= '0;
         m_q   <= 1'b0;
         cnt_q <= '0;
      end else if (load) begin
         w_q   <= bus.i_Din;
         m_q   <= bus.i_Dec;
         cnt_q <= '0;
      end else if (step) begin
         w_q   <= w_rot;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.o_Dout = w_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_iter
// Self-checking bench for sub_bytes_iter. A LANES=4 instance is exercised
// with a scoreboard: the driver pushes the expected result and accept cycle
// on every accept; a monitor pops and compares on every handoff and checks
// latency on every rising o_Valid. Extra instances with LANES=1/2/8/16 run
// the FIPS-197 vector and check result and latency.
// ---------------------------------------------------------------------------
module tb_sub_bytes_iter;

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   logic clk    = 1'b0;
   logic rst    = 1'b0;
   logic sw_rst = 1'b0;
   int   cyc    = 0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sb  [256];
   logic [7:0]   isb [256];
   logic [127:0] exp_q [$];
   int           acc_q [$];
   int           last_acc = -1;
   int           last_ho  = -1;
   bit           b2b_mode = 1'b0;
   bit           rnd_mode = 1'b0;
   int           prev_ho  = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sub_bytes_iter_if bus ();

   sub_bytes_iter #(.LANES(4)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus.slave)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------- reference model (GF arithmetic from first principles)
   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int k = 15; k >= 8; k--)
         if (p[k]) p = p ^ (16'h011b << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] tb_affine(input logic [7:0] x);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         b[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
      return b;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic dec);
      logic [127:0] r;
      for (int k = 0; k < 16; k++)
         r[k*8 +: 8] = dec ? isb[d[k*8 +: 8]] : sb[d[k*8 +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- driver
   task automatic send(input logic [127:0] din, input logic dec, input logic [127:0] exp);
      int n;
      bus.i_Din   = din;
      bus.i_Dec   = dec;
      bus.i_Valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_Ready && n < 100);
      if (!bus.o_Ready) begin
         fail_now("accept_timeout");
         bus.i_Valid = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
      last_acc = cyc + 1;
      @(posedge clk);
      #1;
      // Scramble inputs after accept; the engine must ignore them.
      bus.i_Valid = 1'b0;
      bus.i_Din   = rnd128();
      bus.i_Dec   = ~dec;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor
   initial begin
      logic         v_prev;
      logic [127:0] e;
      int           a;
      v_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            v_prev = 1'b0;
         end else begin
            if (bus.o_Valid && !v_prev) begin
               if (acc_q.size() > 0) begin
                  a = acc_q.pop_front();
                  check("latency", 128'(cyc - a), 128'd4);
               end else begin
                  fail_now("unexpected_valid_rise");
               end
            end
            if (bus.o_Valid && bus.i_Ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("dout", bus.o_Dout, e);
                  last_ho = cyc + 1;
                  if (b2b_mode) begin
                     if (prev_ho >= 0) check("b2b_gap", 128'(last_ho - prev_ho), 128'd5);
                     prev_ho = last_ho;
                  end
               end else begin
                  fail_now("unexpected_handoff");
               end
            end
            v_prev = bus.o_Valid;
         end
      end
   end

   // Random downstream back-pressure during the random phase.
   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) bus.i_Ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- parameter sweep instances
   for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int SL  = (g == 0) ? 1  : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      localparam int SWL = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 2 : 1;

      sub_bytes_iter_if sw_if ();

      sub_bytes_iter #(.LANES(SL)) u_sw (
         .i_Clk (clk),
         .i_Rst (sw_rst),
         .bus   (sw_if.slave)
      );

      initial begin
         int n;
         int a;
         sw_if.i_Valid = 1'b0;
         sw_if.i_Ready = 1'b1;
         sw_if.i_Dec   = 1'b0;
         sw_if.i_Din   = '0;
         #30;
         @(posedge clk);
         #1;
         sw_if.i_Din   = FIPS_IN;
         sw_if.i_Valid = 1'b1;
         @(negedge clk);
         check($sformatf("sweep%0d_ready", SL), sw_if.o_Ready, 1);
         a = cyc + 1;
         @(posedge clk);
         #1;
         sw_if.i_Valid = 1'b0;
         n = 0;
         while (!sw_if.o_Valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("sweep%0d_latency", SL), 128'(cyc - a), 128'(SWL));
         check($sformatf("sweep%0d_dout", SL), sw_if.o_Dout, FIPS_OUT);
      end
   end

   // ---------------- main sequence
   initial begin
      logic [7:0]   inv8;
      logic [127:0] d;
      logic [127:0] hold;
      logic         dec;
      int           n;

      for (int x = 0; x < 256; x++) begin
         inv8 = 8'h00;
         for (int y = 1; y < 256; y++)
            if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv8 = 8'(y);
         sb[x] = tb_affine(inv8);
      end
      for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

      bus.i_Valid = 1'b0;
      bus.i_Ready = 1'b1;
      bus.i_Dec   = 1'b0;
      bus.i_Din   = '0;

      // Reset state.
      #1;
      rst    = 1'b1;
      sw_rst = 1'b1;
      #2;
      check("rst_valid", bus.o_Valid, 0);
      check("rst_ready", bus.o_Ready, 1);
      check("rst_busy",  bus.o_Busy,  0);
      check("rst_dout",  bus.o_Dout,  0);
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      sw_rst = 1'b0;

      // Reset while BUSY with cnt=2: block discarded immediately.
      d = rnd128();
      send(d, 1'b0, model(d, 1'b0));
      check("busy_after_accept", bus.o_Busy, 1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", bus.o_Valid, 0);
      check("midrst_ready", bus.o_Ready, 1);
      check("midrst_busy",  bus.o_Busy,  0);
      check("midrst_dout",  bus.o_Dout,  0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Known-answer vectors.
      send(FIPS_IN, 1'b0, FIPS_OUT);
      drain();
      send(FIPS_OUT, 1'b1, FIPS_IN);
      drain();
      send({16{8'h63}}, 1'b1, '0);
      drain();
      send('0, 1'b1, {16{8'h52}});
      drain();
      send('0, 1'b0, {16{8'h63}});
      drain();

      // Back-pressure: result held 10 cycles while a new block waits.
      bus.i_Ready = 1'b0;
      d = rnd128();
      send(d, 1'b0, model(d, 1'b0));
      n = 0;
      while (!bus.o_Valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", bus.o_Valid, 1);
      hold = bus.o_Dout;
      d    = rnd128();
      fork
         send(d, 1'b1, model(d, 1'b1));
         begin
            repeat (10) begin
               @(negedge clk);
               check("bp_ready", bus.o_Ready, 0);
               check("bp_valid", bus.o_Valid, 1);
               check("bp_dout",  bus.o_Dout,  hold);
            end
            @(posedge clk);
            #1;
            bus.i_Ready = 1'b1;
         end
      join
      check("bp_same_edge", 128'(last_ho), 128'(last_acc));
      drain();

      // Back-to-back, alternating mode.
      b2b_mode = 1'b1;
      prev_ho  = -1;
      for (int k = 0; k < 8; k++) begin
         d   = rnd128();
         dec = k[0];
         send(d, dec, model(d, dec));
      end
      drain();
      b2b_mode = 1'b0;

      // Random blocks with random downstream stalls.
      rnd_mode = 1'b1;
      for (int k = 0; k < 20; k++) begin
         d   = rnd128();
         dec = 1'($urandom_range(0, 1));
         send(d, dec, model(d, dec));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      rnd_mode    = 1'b0;
      bus.i_Ready = 1'b1;
      drain();

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Parametrised, multi-cycle SubBytes engine for the AES core. It applies the forward or inverse S-box to all 16 bytes of a 128-bit state through LANES byte-wide S-box lanes, taking 16/LANES cycles per block. It trades area for latency against the fully parallel 16-lane combinational layers. It sits between the round-key/mix stages and the round controller, and uses a valid/ready handshake on both sides.

## Interface
- LANES, default 4: S-box lanes instantiated; legal values 1, 2, 4, 8, 16; elaboration error otherwise.
- i_Clk  input  1  clock, rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Valid  input  1  input block valid.
- o_Ready  output  1  engine can accept a block this cycle.
- i_Dec  input  1  mode, sampled with the block; 1 = inverse S-box, 0 = forward S-box.
- i_Din  input  128  input state; [127:120] is byte 0, [7:0] is byte 15.
- o_Valid  output  1  result valid; held until taken.
- i_Ready  input  1  downstream accepts the result.
- o_Dout  output  128  substituted state, same byte order as i_Din.
- o_Busy  output  1  high in BUSY.

## Operation
- NCYC = 16/LANES. The working register W is 128 bits. A mode flag M is latched on accept.
- States:
  - IDLE: o_Ready=1. On i_Valid: W<=i_Din, M<=i_Dec, cnt<=0, go to BUSY.
  - BUSY: each cycle, substitute W[LANES*8-1:0] via M-selected S-box. Then W <= {subst, W[127:LANES*8]}, a rotate right by LANES bytes with the substituted bytes placed at the top. cnt++. When cnt==NCYC-1, go to DONE. After NCYC steps W is fully substituted, in original byte order.
  - DONE: o_Valid=1, o_Dout=W.
    - On i_Ready with no i_Valid: go to IDLE.
    - On i_Ready and i_Valid in the same cycle: result handed off and new block loaded, go to BUSY (back-to-back).
    - With no i_Ready: hold W and o_Valid, regardless of i_Valid.
- o_Ready = IDLE | (DONE & i_Ready). This is combinational on i_Ready, with no path from i_Valid.
- i_Din and i_Dec are ignored except on the accept edge. Changes to i_Dec during BUSY have no effect.
- o_Dout equals W in all states. Downstream qualifies it with o_Valid only.
- LANES=16: NCYC=1, so BUSY lasts one cycle.
- No illegal states. An unreachable state encoding returns to IDLE.

## Timing
- Reset, asynchronous and immediate: state=IDLE, W=0, M=0, cnt=0. Outputs: o_Valid=0, o_Busy=0, o_Ready=1, o_Dout=0.
- Reset mid-BUSY or in DONE discards the block. No o_Valid pulse follows.
- Latency: the accept edge is E0. o_Valid rises after edge E_NCYC. For LANES=4 that is 4 cycles.
- Throughput with i_Ready tied high: one block per NCYC+1 cycles, via the back-to-back accept in DONE.
- Critical path: one S-box lookup plus a 2:1 mode mux. No combinational path from i_Din to o_Dout.
- cnt width is clog2(NCYC), minimum 1 bit.

## Structure
- Package aes_sb_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - function ncyc(LANES);
  - the legal-LANES check.
- Sub-module sub_bytes_lane is one byte lane.
  - Ports: 8-bit in, i_Dec, 8-bit out.
  - It instantiates the existing forward and inverse S-box modules and muxes their outputs on i_Dec.
  - It is instantiated LANES times in a generate loop.

## Test plan
- Reset/idle: assert i_Rst mid-BUSY (LANES=4, cnt=2) -> o_Valid=0, o_Ready=1, o_Dout=0 immediately. Next accepted block completes normally.
- Forward known-answer, FIPS-197 round 1, i_Dec=0, LANES=4:
  - i_Din = 193de3bea0f4e22b9ac68d2ae9f84808 -> o_Dout = d42711aee0bf98f1b8b45de51e415230.
  - o_Valid rises exactly 4 cycles after accept.
- Inverse round trip, i_Dec=1:
  - i_Din = d42711aee0bf98f1b8b45de51e415230 -> 193de3bea0f4e22b9ac68d2ae9f84808.
  - All-0x63 -> all-0x00; all-0x00 -> all-0x52.
- Back-pressure: hold i_Ready=0 for 10 cycles in DONE while i_Valid=1 -> o_Dout stable, o_Ready=0, no accept. Raise i_Ready -> handoff and new accept on the same edge.
- Back-to-back: i_Valid and i_Ready tied high, alternating i_Dec, 8 blocks -> one o_Valid every 5 cycles (LANES=4), each result matches the software model.
- Parameter sweep: LANES=1, 2, 8, 16 on the FIPS vector -> correct result, latencies 16/8/2/1. LANES=3 -> elaboration error.
